// File: rtl/rf_seq_pkg.sv
// Shared definitions for the RF pulse sequencer and its receive-side decoder:
// decoder FSM states, report error codes and the nominal sequencer timing.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_CHECK = 3'd4
  } rf_state_e;

  localparam logic [1:0] SEQ_ERR_NONE     = 2'd0;
  localparam logic [1:0] SEQ_ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] SEQ_ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] SEQ_ERR_MISMATCH = 2'd3;

  // Nominal sequencer timing in clock cycles.
  localparam int unsigned SEQ_IDLE_CYCLES = 32'd1000;
  localparam int unsigned SEQ_PI2_CYCLES  = 32'd333;
  localparam int unsigned SEQ_PI_CYCLES   = 32'd666;

endpackage

// File: rtl/rf_sync2.sv
// Two-flop synchronizer for the asynchronous RF gate line. Flops reset to 1
// so that the line reads as "busy" until it is genuinely seen low.
module rf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronisation of d_i into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rf_pulse_decoder.sv
// Measures a three-pulse pi/2 - pi - pi/2 train on the rf line and issues a
// one-cycle report with widths, gaps and a pass/fail verdict.
// Optional macro RF_DECODE_SYNC_EN inserts a 2-flop synchronizer ahead of
// the sampling register (for an rf line not generated on clk).
module rf_pulse_decoder
  import rf_seq_pkg::*;
#(
  parameter int CNT_W        = 17,
  parameter int TOL          = 2,
  parameter int IDLE_TIMEOUT = 1500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rf,
  output logic             seq_valid,
  output logic             seq_ok,
  output logic [1:0]       seq_err,
  output logic [CNT_W-1:0] w0,
  output logic [CNT_W-1:0] w1,
  output logic [CNT_W-1:0] w2,
  output logic [CNT_W-1:0] g0,
  output logic [CNT_W-1:0] g1
);

  localparam int DW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(IDLE_TIMEOUT);
  localparam logic [DW-1:0]    TOL_C     = DW'(TOL);

  // Absolute difference without wrap; operands are pre-extended to DW bits.
  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  logic rf_in_s;

`ifdef RF_DECODE_SYNC_EN
  rf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rf),
    .q_o (rf_in_s)
  );
`else
  assign rf_in_s = rf;
`endif

  logic rf_s_q;

  // Single sampling register; every FSM decision is taken on rf_s_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_s_q <= 1'b1;
    end else begin
      rf_s_q <= rf_in_s;
    end
  end

  rf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] mw0_q, mw0_d, mw1_q, mw1_d, mw2_q, mw2_d;
  logic [CNT_W-1:0] mg0_q, mg0_d, mg1_q, mg1_d;

  logic             valid_q, valid_d;
  logic             ok_q, ok_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] rw0_q, rw0_d, rw1_q, rw1_d, rw2_q, rw2_d;
  logic [CNT_W-1:0] rg0_q, rg0_d, rg1_q, rg1_d;

  logic [CNT_W-1:0] cnt_inc_s;
  logic             pass_s;

  // Saturating increment of the shared width/gap counter.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Area-ratio and gap-symmetry checks on the measured train.
  always_comb begin
    logic [DW-1:0] w0x, w1x, w2x, g0x, g1x;
    w0x    = DW'(mw0_q);
    w1x    = DW'(mw1_q);
    w2x    = DW'(mw2_q);
    g0x    = DW'(mg0_q);
    g1x    = DW'(mg1_q);
    pass_s = (abs_diff(w2x, w0x) <= TOL_C) &&
             (abs_diff(w1x, w0x << 1) <= TOL_C) &&
             (abs_diff(g1x, g0x) <= TOL_C);
  end

  // Measurement FSM and report generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    mw0_d   = mw0_q;
    mw1_d   = mw1_q;
    mw2_d   = mw2_q;
    mg0_d   = mg0_q;
    mg1_d   = mg1_q;
    valid_d = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    rw0_d   = rw0_q;
    rw1_d   = rw1_q;
    rw2_d   = rw2_q;
    rg0_d   = rg0_q;
    rg1_d   = rg1_q;

    case (state_q)
      ST_ARM: begin
        // A pulse already high at reset release is not a complete pulse.
        if (!rf_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end

      ST_IDLE: begin
        if (rf_s_q) begin
          mw0_d   = '0;
          mw1_d   = '0;
          mw2_d   = '0;
          mg0_d   = '0;
          mg1_d   = '0;
          idx_d   = 2'd0;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HIGH: begin
        if (rf_s_q) begin
          cnt_d = cnt_inc_s;
          ovf_d = ovf_q | (cnt_inc_s == CNT_MAX);
        end else begin
          case (idx_q)
            2'd0:    mw0_d = cnt_q;
            2'd1:    mw1_d = cnt_q;
            default: mw2_d = cnt_q;
          endcase
          cnt_d = CNT_ONE;
          if (idx_q == 2'd2) begin
            state_d = ST_CHECK;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LOW;
          end
        end
      end

      ST_LOW: begin
        // Timeout wins over a rising edge seen on the same cycle.
        if (cnt_q == TIMEOUT_C) begin
          tmo_d   = 1'b1;
          state_d = ST_CHECK;
        end else if (!rf_s_q) begin
          cnt_d = cnt_inc_s;
          ovf_d = ovf_q | (cnt_inc_s == CNT_MAX);
        end else begin
          // idx is 1 after pulse 1 and 2 after pulse 2; bit 1 selects the gap.
          if (idx_q[1]) begin
            mg1_d = cnt_q;
          end else begin
            mg0_d = cnt_q;
          end
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end

      ST_CHECK: begin
        valid_d = 1'b1;
        rw0_d   = mw0_q;
        rw1_d   = mw1_q;
        rw2_d   = mw2_q;
        rg0_d   = mg0_q;
        rg1_d   = mg1_q;
        if (tmo_q) begin
          ok_d  = 1'b0;
          err_d = SEQ_ERR_TIMEOUT;
        end else if (ovf_q) begin
          ok_d  = 1'b0;
          err_d = SEQ_ERR_OVERFLOW;
        end else if (!pass_s) begin
          ok_d  = 1'b0;
          err_d = SEQ_ERR_MISMATCH;
        end else begin
          ok_d  = 1'b1;
          err_d = SEQ_ERR_NONE;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // State, measurement and report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      mw0_q   <= '0;
      mw1_q   <= '0;
      mw2_q   <= '0;
      mg0_q   <= '0;
      mg1_q   <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= SEQ_ERR_NONE;
      rw0_q   <= '0;
      rw1_q   <= '0;
      rw2_q   <= '0;
      rg0_q   <= '0;
      rg1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      mw0_q   <= mw0_d;
      mw1_q   <= mw1_d;
      mw2_q   <= mw2_d;
      mg0_q   <= mg0_d;
      mg1_q   <= mg1_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      rw0_q   <= rw0_d;
      rw1_q   <= rw1_d;
      rw2_q   <= rw2_d;
      rg0_q   <= rg0_d;
      rg1_q   <= rg1_d;
    end
  end

  assign seq_valid = valid_q;
  assign seq_ok    = ok_q;
  assign seq_err   = err_q;
  assign w0        = rw0_q;
  assign w1        = rw1_q;
  assign w2        = rw2_q;
  assign g0        = rg0_q;
  assign g1        = rg1_q;

endmodule

// File: tb/tb_rf_pulse_decoder.sv
// Directed self-checking bench for rf_pulse_decoder. A default-parameter
// instance and a narrow-counter instance (CNT_W=6) observe the same rf line.
module tb_rf_pulse_decoder;

`ifdef RF_DECODE_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rf;
  logic        seq_valid, seq_ok;
  logic [1:0]  seq_err;
  logic [16:0] w0, w1, w2, g0, g1;
  logic        s_valid, s_ok;
  logic [1:0]  s_err;
  logic [5:0]  s_w0, s_w1, s_w2, s_g0, s_g1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        ok;
    logic [1:0]  err;
    logic [16:0] w0, w1, w2, g0, g1;
  } rep_t;

  rep_t rq[$];
  rep_t sq[$];

  rf_pulse_decoder dut (
    .clk(clk), .rst(rst), .rf(rf),
    .seq_valid(seq_valid), .seq_ok(seq_ok), .seq_err(seq_err),
    .w0(w0), .w1(w1), .w2(w2), .g0(g0), .g1(g1)
  );

  rf_pulse_decoder #(.CNT_W(6), .TOL(2), .IDLE_TIMEOUT(50)) dut_small (
    .clk(clk), .rst(rst), .rf(rf),
    .seq_valid(s_valid), .seq_ok(s_ok), .seq_err(s_err),
    .w0(s_w0), .w1(s_w1), .w2(s_w2), .g0(s_g0), .g1(s_g1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every report with the index of the edge after which it appeared.
  always @(negedge clk) begin
    rep_t r;
    if (seq_valid) begin
      r.cyc = cyc; r.ok = seq_ok; r.err = seq_err;
      r.w0 = w0; r.w1 = w1; r.w2 = w2; r.g0 = g0; r.g1 = g1;
      rq.push_back(r);
    end
    if (s_valid) begin
      r.cyc = cyc; r.ok = s_ok; r.err = s_err;
      r.w0 = 17'(s_w0); r.w1 = 17'(s_w1); r.w2 = 17'(s_w2);
      r.g0 = 17'(s_g0); r.g1 = 17'(s_g1);
      sq.push_back(r);
    end
  end

  // Hold rf at level for n sampling edges (called and returning at negedge).
  task automatic drive(input logic level, input int n);
    rf = level;
    repeat (n) @(negedge clk);
  endtask

  // Drive a full train; e is the first edge sampling rf=0 after pulse 3.
  task automatic run_train(input int lead, input int a, input int ga, input int b,
                           input int gb, input int c, input int tail, output int e);
    drive(1'b0, lead);
    drive(1'b1, a);
    drive(1'b0, ga);
    drive(1'b1, b);
    drive(1'b0, gb);
    drive(1'b1, c);
    e = cyc + 1;
    drive(1'b0, tail);
    #1;
  endtask

  task automatic test_reset();
    int e, n0;
    rst = 1'b1;
    rf  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({seq_valid, seq_ok, seq_err, w0, w1, w2, g0, g1} !== 89'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {seq_valid, seq_ok, seq_err, w0, w1, w2, g0, g1});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 15);
    n0 = rq.size();
    run_train(20, 10, 30, 20, 30, 10, 8, e);
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL startup_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1} !==
          {1'b1, 2'd0, 17'd10, 17'd20, 17'd10, 17'd30, 17'd30}) begin
        errors++;
        $display("FAIL startup_report got ok=%0d err=%0d w=%0d/%0d/%0d g=%0d/%0d want ok=1 err=0 w=10/20/10 g=30/30",
                 rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1);
      end
    end
  endtask

  task automatic test_nominal();
    int e, n0;
    n0 = rq.size();
    run_train(20, 10, 30, 20, 30, 10, 8, e);
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL nominal_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if (rq[n0].cyc != e + LAT) begin
        errors++;
        $display("FAIL nominal_latency got edge %0d want %0d", rq[n0].cyc, e + LAT);
      end
      checks++;
      if ({rq[n0].ok, rq[n0].err} !== {1'b1, 2'd0}) begin
        errors++;
        $display("FAIL nominal_verdict got ok=%0d err=%0d want ok=1 err=0", rq[n0].ok, rq[n0].err);
      end
      checks++;
      if ({rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1} !==
          {17'd10, 17'd20, 17'd10, 17'd30, 17'd30}) begin
        errors++;
        $display("FAIL nominal_fields got w=%0d/%0d/%0d g=%0d/%0d want w=10/20/10 g=30/30",
                 rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1);
      end
    end
    // Report fields must hold after the strobe.
    checks++;
    if ({seq_valid, seq_ok, w1, g1} !== {1'b0, 1'b1, 17'd20, 17'd30}) begin
      errors++;
      $display("FAIL nominal_hold got valid=%0d ok=%0d w1=%0d g1=%0d want 0/1/20/30", seq_valid, seq_ok, w1, g1);
    end
  endtask

  task automatic test_pi_mismatch();
    int e, n0;
    n0 = rq.size();
    run_train(20, 10, 30, 25, 30, 10, 8, e);
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL pi_mismatch_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].ok, rq[n0].err, rq[n0].w1} !== {1'b0, 2'd3, 17'd25}) begin
        errors++;
        $display("FAIL pi_mismatch got ok=%0d err=%0d w1=%0d want ok=0 err=3 w1=25", rq[n0].ok, rq[n0].err, rq[n0].w1);
      end
    end
  endtask

  task automatic test_gap_asym();
    int e, n0;
    n0 = rq.size();
    run_train(20, 10, 30, 20, 40, 10, 8, e);
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL gap_asym_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].ok, rq[n0].err, rq[n0].g0, rq[n0].g1} !== {1'b0, 2'd3, 17'd30, 17'd40}) begin
        errors++;
        $display("FAIL gap_asym got ok=%0d err=%0d g=%0d/%0d want ok=0 err=3 g=30/40",
                 rq[n0].ok, rq[n0].err, rq[n0].g0, rq[n0].g1);
      end
    end
  endtask

  task automatic test_timeout();
    int l, n0;
    n0 = rq.size();
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 30);
    drive(1'b1, 20);
    l = cyc + 1;
    drive(1'b0, 1520);
    #1;
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL timeout_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if (rq[n0].cyc != l + 1500 + LAT) begin
        errors++;
        $display("FAIL timeout_latency got edge %0d want %0d", rq[n0].cyc, l + 1500 + LAT);
      end
      checks++;
      if ({rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1} !==
          {1'b0, 2'd1, 17'd10, 17'd20, 17'd0, 17'd30, 17'd0}) begin
        errors++;
        $display("FAIL timeout_report got ok=%0d err=%0d w=%0d/%0d/%0d g=%0d/%0d want ok=0 err=1 w=10/20/0 g=30/0",
                 rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1);
      end
    end
  endtask

  task automatic test_overflow();
    int e, n0, s0;
    drive(1'b0, 60);
    n0 = rq.size();
    s0 = sq.size();
    run_train(0, 70, 10, 20, 10, 10, 8, e);
    checks++;
    if (sq.size() != s0 + 1) begin
      errors++;
      $display("FAIL overflow_count got %0d want 1", sq.size() - s0);
    end else begin
      checks++;
      if ({sq[s0].cyc, sq[s0].ok, sq[s0].err, sq[s0].w0} !== {e + LAT, 1'b0, 2'd2, 17'd63}) begin
        errors++;
        $display("FAIL overflow_report got edge=%0d ok=%0d err=%0d w0=%0d want edge=%0d ok=0 err=2 w0=63",
                 sq[s0].cyc, sq[s0].ok, sq[s0].err, sq[s0].w0, e + LAT);
      end
    end
    // The wide instance measures the same train without overflow.
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL wide_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1} !==
          {2'd3, 17'd70, 17'd20, 17'd10, 17'd10, 17'd10}) begin
        errors++;
        $display("FAIL wide_report got err=%0d w=%0d/%0d/%0d g=%0d/%0d want err=3 w=70/20/10 g=10/10",
                 rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, n0;
    n0 = rq.size();
    run_train(20, 10, 30, 20, 30, 10, 2, e1);
    run_train(0, 12, 20, 24, 20, 12, 8, e2);
    checks++;
    if (rq.size() != n0 + 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].cyc, rq[n0 + 1].cyc} !== {e1 + LAT, e2 + LAT}) begin
        errors++;
        $display("FAIL b2b_latency got %0d,%0d want %0d,%0d", rq[n0].cyc, rq[n0 + 1].cyc, e1 + LAT, e2 + LAT);
      end
      checks++;
      if ({rq[n0 + 1].ok, rq[n0 + 1].err, rq[n0 + 1].w0, rq[n0 + 1].w1, rq[n0 + 1].w2, rq[n0 + 1].g0, rq[n0 + 1].g1} !==
          {1'b1, 2'd0, 17'd12, 17'd24, 17'd12, 17'd20, 17'd20}) begin
        errors++;
        $display("FAIL b2b_second got ok=%0d err=%0d w=%0d/%0d/%0d g=%0d/%0d want ok=1 err=0 w=12/24/12 g=20/20",
                 rq[n0 + 1].ok, rq[n0 + 1].err, rq[n0 + 1].w0, rq[n0 + 1].w1, rq[n0 + 1].w2,
                 rq[n0 + 1].g0, rq[n0 + 1].g1);
      end
    end
  endtask

  task automatic test_reset_mid_train();
    int n0;
    n0 = rq.size();
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 30);
    drive(1'b1, 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 10);
    drive(1'b0, 60);
    #1;
    checks++;
    if (rq.size() != n0) begin
      errors++;
      $display("FAIL mid_reset_count got %0d want 0", rq.size() - n0);
    end
    checks++;
    if ({seq_valid, seq_ok, seq_err, w0, w1, w2, g0, g1} !== 89'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0", {seq_valid, seq_ok, seq_err, w0, w1, w2, g0, g1});
    end
  endtask

  task automatic test_sequencer_loop();
    int e, n0;
    n0 = rq.size();
    run_train(20, 334, 1001, 667, 1001, 334, 8, e);
    checks++;
    if (rq.size() != n0 + 1) begin
      errors++;
      $display("FAIL seq_loop_count got %0d want 1", rq.size() - n0);
    end else begin
      checks++;
      if ({rq[n0].cyc, rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1} !==
          {e + LAT, 1'b1, 2'd0, 17'd334, 17'd667, 17'd334, 17'd1001, 17'd1001}) begin
        errors++;
        $display("FAIL seq_loop got edge=%0d ok=%0d err=%0d w=%0d/%0d/%0d g=%0d/%0d want edge=%0d ok=1 err=0 w=334/667/334 g=1001/1001",
                 rq[n0].cyc, rq[n0].ok, rq[n0].err, rq[n0].w0, rq[n0].w1, rq[n0].w2, rq[n0].g0, rq[n0].g1, e + LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rf  = 1'b1;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_pi_mismatch();
    test_gap_asym();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid_train();
    test_sequencer_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
